// File: rtl/calc_uart_pkg.sv
// Shared definitions for the calculator console path.
// Contents:
//   - ASCII constants used by the result printer
//   - state encoding of the result transmitter FSM
//   - calculator op codes
//   - ascii_digit(): BCD nibble to ASCII character
package calc_uart_pkg;

  localparam logic [7:0] AsciiZero = 8'h30;
  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiE    = 8'h45;
  localparam logic [7:0] AsciiR    = 8'h52;

  localparam int unsigned BinWidth  = 32;
  localparam int unsigned BcdDigits = 10;

  typedef enum logic [2:0] {
    StIdle,
    StConv,
    StSend,
    StHold,
    StFinish
  } tx_state_e;

  typedef enum logic [2:0] {
    OpMult    = 3'b000,
    OpDiv     = 3'b001,
    OpSqrt    = 3'b010,
    OpB2Bcd   = 3'b011,
    OpBcd2B   = 3'b100,
    OpInvalid = 3'b111
  } calc_op_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return AsciiZero + {4'b0000, d};
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential 32-bit double-dabble converter, one bit per cycle.
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-high reset
//   start_i - load bin_i and begin conversion
//   bin_i   - binary value, sampled only with start_i
//   done_o  - high in the cycle whose rising edge performs the final iteration;
//             bcd_o holds the complete result from the following cycle on
//   bcd_o   - 10 BCD digits, digit 0 in bits [3:0]
module bin_to_bcd_seq
  import calc_uart_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [BinWidth-1:0]     bin_i,
  output logic                    done_o,
  output logic [4*BcdDigits-1:0]  bcd_o
);

  logic [BinWidth-1:0]    bin_q;
  logic [4*BcdDigits-1:0] bcd_q;
  logic [4*BcdDigits-1:0] adj;
  logic [4*BcdDigits-1:0] shifted;
  logic [4:0]             cnt_q;

  // Add 3 to every digit >= 5 so the following shift carries correctly.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BcdDigits; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = (adj << 1) | {{(4*BcdDigits-1){1'b0}}, bin_q[BinWidth-1]};
  end

  // The load cycle already performs iteration 1 (adjusting an all-zero BCD
  // is a no-op), so 31 more iterations follow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      bin_q <= {bin_i[BinWidth-2:0], 1'b0};
      bcd_q <= {{(4*BcdDigits-1){1'b0}}, bin_i[BinWidth-1]};
      cnt_q <= 5'd31;
    end else if (cnt_q != 5'd0) begin
      bin_q <= bin_q << 1;
      bcd_q <= shifted;
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign done_o = (cnt_q == 5'd1);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_result_tx.sv
// Prints a 32-bit result as unsigned decimal ASCII (or "ERR"), optionally
// followed by CR LF, one byte at a time into a UART transmitter.
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-high reset
//   result       - value to print, sampled on acceptance
//   result_valid - request strobe, accepted only while busy is low
//   error        - sampled with result_valid; prints "ERR" instead
//   tx_data      - byte to UART, held from tx_start until the next byte
//   tx_start     - one-cycle pulse per byte
//   tx_busy      - UART busy
//   busy         - request in progress
//   done         - one-cycle pulse after the final byte completes
module uart_result_tx
  import calc_uart_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BinWidth-1:0] result,
  input  logic                result_valid,
  input  logic                error,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic                busy,
  output logic                done
);

  tx_state_e        state_q;
  logic             err_q;
  logic [3:0]       cnt_q;     // characters already sent
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             busy_q;
  logic             done_q;

  logic                   accept;
  logic                   conv_start;
  logic                   conv_last;
  logic [4*BcdDigits-1:0] bcd;
  logic [3:0]             lead;
  logic [3:0]             ndig;
  logic [3:0]             total;
  logic [3:0]             didx;
  logic [3:0]             cnt_inc;
  logic [7:0]             cur_char;

  assign accept     = result_valid && !busy_q;
  assign conv_start = accept && !error;

  bin_to_bcd_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start_i (conv_start),
    .bin_i   (result),
    .done_o  (conv_last),
    .bcd_o   (bcd)
  );

  // Character stream: digits from the leading nonzero one down to digit 0,
  // then CR LF. An all-zero value leaves lead at 0 and prints one "0".
  always_comb begin
    lead = 4'd0;
    for (int i = 0; i < BcdDigits; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        lead = 4'(i);
      end
    end
    ndig  = lead + 4'd1;
    total = err_q ? 4'd3 : ndig;
    if (SEND_CRLF) begin
      total = total + 4'd2;
    end
    didx    = lead - cnt_q;
    cnt_inc = cnt_q + 4'd1;

    cur_char = 8'h00;
    if (err_q) begin
      unique case (cnt_q)
        4'd0:       cur_char = AsciiE;
        4'd1, 4'd2: cur_char = AsciiR;
        4'd3:       cur_char = AsciiCr;
        default:    cur_char = AsciiLf;
      endcase
    end else if (cnt_q < ndig) begin
      cur_char = ascii_digit(bcd[{didx, 2'b00} +: 4]);
    end else if (cnt_q == ndig) begin
      cur_char = AsciiCr;
    end else begin
      cur_char = AsciiLf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      err_q      <= 1'b0;
      cnt_q      <= 4'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        // FINISH holds the done pulse; busy is already low, so it may accept.
        StIdle, StFinish: begin
          done_q     <= 1'b0;
          tx_start_q <= 1'b0;
          state_q    <= StIdle;
          if (accept) begin
            busy_q  <= 1'b1;
            err_q   <= error;
            cnt_q   <= 4'd0;
            state_q <= error ? StSend : StConv;
          end
        end
        StConv: begin
          if (conv_last) begin
            state_q <= StSend;
          end
        end
        StSend: begin
          if (!tx_busy) begin
            tx_data_q  <= cur_char;
            tx_start_q <= 1'b1;
            state_q    <= StHold;
          end
        end
        StHold: begin
          tx_start_q <= 1'b0;
          // tx_start_q still high marks the cycle right after the pulse,
          // where the UART may not have raised tx_busy yet.
          if (!tx_start_q && !tx_busy) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == total) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFinish;
            end else begin
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
module tb_uart_result_tx;

  localparam bit Crlf = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] result = '0;
  logic        result_valid = 1'b0;
  logic        error = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_result_tx #(.SEND_CRLF(Crlf)) dut (
    .clk          (clk),
    .reset        (reset),
    .result       (result),
    .result_valid (result_valid),
    .error        (error),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_busy      (tx_busy),
    .busy         (busy),
    .done         (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_q[$];
  time        got_t[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         done_busy_bad = 0;
  int         viol_cnt = 0;
  int         uart_cnt = 0;
  bit         stall_en = 1'b0;

  // UART model: captures bytes, busy for a random 1..4 cycles per byte, or
  // 100 cycles after the second byte when stalling is enabled.
  always @(negedge clk) begin
    if (reset) begin
      uart_cnt = 0;
      tx_busy  = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
      if (tx_start) begin
        if (tx_busy) viol_cnt++;
        got_q.push_back(tx_data);
        got_t.push_back($time);
        uart_cnt = (stall_en && got_q.size() == 2) ? 100 : int'($urandom_range(1, 4));
      end else if (uart_cnt > 0) begin
        uart_cnt--;
      end
      tx_busy = (uart_cnt != 0);
    end
  end

  // Reference: the decimal string of the value, or ERR, plus CR LF.
  task automatic make_exp(input logic [31:0] v, input bit err);
    string s;
    exp_q.delete();
    s = err ? "ERR" : $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    if (Crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  function automatic string hexq(input logic [7:0] q[$]);
    string s = "";
    for (int i = 0; i < q.size(); i++) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic bit same_bytes();
    if (got_q.size() != exp_q.size()) return 1'b0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_obs();
    got_q.delete();
    got_t.delete();
    done_cnt      = 0;
    done_busy_bad = 0;
    viol_cnt      = 0;
  endtask

  // One request; reports first tx_start cycle (acceptance = cycle 0),
  // busy in cycle 1, and whether done arrived within the bound.
  task automatic send_req(input logic [31:0] v, input bit err,
                          output int lat, output logic busy1, output bit ok);
    clear_obs();
    @(negedge clk);
    result = v; error = err; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0; result = $urandom; error = 1'($urandom);
    busy1 = busy;
    lat = -1;
    for (int c = 1; c < 200; c++) begin
      if (tx_start) begin lat = c; break; end
      @(negedge clk);
    end
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_data, tx_start, busy, done} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 000", {tx_data, tx_start, busy, done});
    end
    // Request presented during reset must not be accepted.
    result = 32'd99; result_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_wins: busy got %b required 0", busy);
    end
    result_valid = 1'b0;
    reset = 1'b0;
    clear_obs();
    repeat (40) @(negedge clk);
    n_cmp++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: bytes got %0d busy %b required 0 0", got_q.size(), busy);
    end
  endtask

  task automatic test_value(input string name, input logic [31:0] v, input bit err,
                            input int exp_lat);
    int lat; logic busy1; bit ok;
    make_exp(v, err);
    send_req(v, err, lat, busy1, ok);
    n_cmp++;
    if (!ok || !same_bytes()) begin
      n_bad++;
      $display("FAIL %s_bytes: got %s(done=%0b) required %s", name, hexq(got_q), ok, hexq(exp_q));
    end
    n_cmp++;
    if (lat !== exp_lat || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timing: first tx_start cycle %0d busy@1 %b required %0d 1",
               name, lat, busy1, exp_lat);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_busy_bad !== 0 || viol_cnt !== 0) begin
      n_bad++;
      $display("FAIL %s_handshake: done %0d done_with_busy %0d start_while_busy %0d required 1 0 0",
               name, done_cnt, done_busy_bad, viol_cnt);
    end
  endtask

  task automatic test_zero();
    test_value("zero", 32'd0, 1'b0, 33);
  endtask

  task automatic test_digits();
    test_value("d12345", 32'd12345, 1'b0, 33);
    test_value("max", 32'hFFFF_FFFF, 1'b0, 33);
    test_value("ten", 32'd10, 1'b0, 33);
  endtask

  task automatic test_error();
    test_value("err7", 32'd7, 1'b1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] v;
      bit e;
      v = $urandom >> $urandom_range(0, 31);
      e = ($urandom_range(0, 4) == 0);
      test_value($sformatf("rnd%0d", i), v, e, e ? 2 : 33);
    end
  endtask

  task automatic test_stall_drop();
    bit ok = 1'b0;
    bit pulsed = 1'b0;
    int n_before;
    stall_en = 1'b1;
    clear_obs();
    make_exp(32'd987654, 1'b0);
    @(negedge clk);
    result = 32'd987654; error = 1'b0; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!pulsed && got_q.size() >= 2 && tx_busy) begin
        result = 32'd5; error = 1'b0; result_valid = 1'b1; pulsed = 1'b1;
      end else begin
        result_valid = 1'b0;
      end
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    result_valid = 1'b0;
    repeat (3) @(negedge clk);
    stall_en = 1'b0;
    n_cmp++;
    if (!ok || !same_bytes()) begin
      n_bad++;
      $display("FAIL stall_bytes: got %s(done=%0b) required %s", hexq(got_q), ok, hexq(exp_q));
    end
    n_cmp++;
    if (viol_cnt !== 0 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL stall_handshake: start_while_busy %0d done %0d required 0 1",
               viol_cnt, done_cnt);
    end
    n_cmp++;
    if (got_t.size() < 3 || (got_t[2] - got_t[1]) < 1000) begin
      n_bad++;
      $display("FAIL stall_gap: 3rd byte too early or missing, bytes %0d required gap >= 100 cycles",
               got_t.size());
    end
    n_before = got_q.size();
    repeat (60) @(negedge clk);
    n_cmp++;
    if (got_q.size() !== n_before || busy !== 1'b0 || done_cnt !== 1) begin
      n_bad++;
      $display("FAIL dropped_request: bytes %0d->%0d busy %b done %0d required unchanged 0 1",
               n_before, got_q.size(), busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic busy1; bit ok;
    bit reached = 1'b0;
    clear_obs();
    @(negedge clk);
    result = 32'd12345; error = 1'b0; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (got_q.size() >= 2) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (!reached || {tx_data, tx_start, busy, done} !== 11'd0) begin
      n_bad++;
      $display("FAIL async_reset: reached=%0b outputs got %h required 000",
               reached, {tx_data, tx_start, busy, done});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_value("after_reset42", 32'd42, 1'b0, 33);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_digits();
    test_error();
    test_random();
    test_stall_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_result_tx.md
# uart_result_tx

Formats a 32-bit calculator result as an unsigned ASCII decimal string terminated by CR LF and streams it byte by byte into the UART transmitter. It sits between the calculator core's result/result_ready outputs and the UART TX byte interface (tx_data/tx_start/tx_busy). It completes the console path: commands arrive over RX, and this block returns human-readable answers over TX.

## Interface
- SEND_CRLF, default 1: append 0x0D 0x0A after every string; 0 sends digits (or ERR) only.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- result  input  32  unsigned value to print; sampled only on acceptance.
- result_valid  input  1  request strobe; accepted only when busy=0.
- error  input  1  sampled with result_valid; 1 → send "ERR" instead of the number.
- tx_data  output  8  ASCII byte to the UART; held stable from tx_start until the next byte.
- tx_start  output  1  one-cycle pulse per byte.
- tx_busy  input  1  UART busy; rises no later than the cycle after tx_start.
- busy  output  1  high from acceptance until the last byte completes.
- done  output  1  one-cycle pulse when the final byte's tx_busy falls.

## Operation
- Reset values: tx_data=0x00, tx_start=0, busy=0, done=0, state=IDLE, all digit registers 0.
- States: IDLE → CONV → SEND → HOLD → (SEND | FINISH) → IDLE.
- IDLE: on result_valid&&!busy, latch result and error, set busy, and go to CONV. If error=1, skip CONV and load the char queue "ERR".
- CONV: sequential double-dabble over 32 cycles produces 10 BCD digits. In each cycle, add 3 to every digit ≥5, then shift left one bit. At the end, a combinational priority encoder picks the first nonzero digit index. An all-zero value sends a single "0".
- SEND: when tx_busy=0, drive tx_data = 0x30+digit (or the ERR char) and pulse tx_start, then go to HOLD.
- HOLD: ignore tx_busy in the first cycle after the pulse, then wait for tx_busy=0. Advance the pointer. Return to SEND if chars remain, including CR and LF when SEND_CRLF=1; otherwise go to FINISH.
- FINISH: pulse done, clear busy, go to IDLE.
- result_valid while busy=1 is dropped, with no queueing.
- Simultaneous result_valid and reset: reset wins.
- Reset mid-string: the string is abandoned and the next request starts clean. No partial-state carryover.

## Timing
- Acceptance at cycle 0, busy=1 at cycle 1.
- Numeric path: CONV spans cycles 1–32. The first tx_start comes at cycle 33 if tx_busy=0.
- Error path: the first tx_start comes at cycle 2.
- Per byte: at least 3 cycles between tx_start pulses. Otherwise the pace is set entirely by tx_busy.
- Done comes 1 cycle after tx_busy falls for the final byte. busy falls in the same cycle as done.
- tx_start is never asserted while tx_busy=1.

## Structure
- Shared package calc_uart_pkg:
  - ASCII constants: ZERO 0x30, CR 0x0D, LF 0x0A, "E" 0x45, "R" 0x52.
  - State encoding.
  - Calculator op codes (MULT 000, DIV 001, SQRT 010, B2BCD 011, BCD2B 100, invalid 111).
- Sub-module bin_to_bcd_seq: 32-bit sequential double-dabble with start/done and a 40-bit BCD output. The top level contains the FSM, digit pointer, and TX handshake.

## Test plan
- result=0 → bytes 0x30,0x0D,0x0A, then one done pulse.
- result=12345 → 0x31,0x32,0x33,0x34,0x35,0x0D,0x0A, with no leading zeros.
- result=0xFFFFFFFF → "4294967295" (0x34…0x35, 10 digits) plus CR LF, 12 bytes.
- error=1, result=7 → 0x45,0x52,0x52,0x0D,0x0A. The first tx_start comes at cycle 2.
- tx_busy forced high for 100 cycles after the 2nd byte, plus result_valid pulsed mid-string:
  - no tx_start occurs while busy;
  - no byte is dropped or duplicated;
  - the extra request is ignored.
- reset asserted while the 3rd byte is pending:
  - all outputs return to 0 asynchronously;
  - a new request for 42 afterward yields 0x34,0x32,0x0D,0x0A.
